gaussian_blur: RTL
==================

# gaussian_blur

- Streaming 5x5 Gaussian smoothing stage of the lane/Hough pipeline, directly upstream of the Sobel stage.
- Reads 8-bit grayscale pixels in raster order from an input FIFO.
- Filters each interior pixel with a separable binomial kernel and writes one 8-bit pixel per input pixel to the output FIFO.
- The output FIFO is the Sobel stage's input.
- Frame size is fixed by parameters; the block rearms itself after every frame.

## Interface
- WIDTH, default 64: pixels per row of the (reduced) frame; minimum 5.
- HEIGHT, default 64: rows per frame; minimum 5.
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- in_rd_en  out  1  pops in_dout this cycle; never asserted while in_empty=1 or reset=1.
- in_empty  in  1  input FIFO empty.
- in_dout  in  8  input pixel, valid when in_empty=0.
- out_wr_en  out  1  pushes out_din this cycle; never asserted while out_full=1 or reset=1.
- out_full  in  1  output FIFO full.
- out_din  out  8  filtered pixel, meaningful only when out_wr_en=1; otherwise 0.

## Operation
- Shift register: length L=4*WIDTH+5, 8-bit entries. Each shift moves every entry one position older and loads the newest pixel at position L-1.
- Center pixel: position C=2*WIDTH+2.
- Window tap (dr,dc), dr,dc in -2..2: position C+dr*WIDTH+dc.
- Counters: read_cnt (pixels popped this frame, 0..WIDTH*HEIGHT), prologue counter, row and col of the current center pixel.
- States:
  - PROLOGUE: pop whenever in_empty=0 (in_rd_en=!in_empty). On the cycle the (2*WIDTH+3)-th pixel is popped, go to COMPUTE; center is now pixel (0,0).
  - COMPUTE: one cycle. Register the result for the center pixel (row,col), then go to WRITE.
  - WRITE: hold out_din=result and out_wr_en=!out_full. On an accepted write:
    - if row=HEIGHT-1 and col=WIDTH-1, clear row, col, read_cnt, the prologue counter and the shift register, then go to PROLOGUE;
    - otherwise advance col, wrapping to 0 and incrementing row at col=WIDTH-1, then go to ADVANCE.
  - ADVANCE: if read_cnt<WIDTH*HEIGHT, wait for in_empty=0, then pop, shift in in_dout and go to COMPUTE. Otherwise shift in 8'h00 without popping and go to COMPUTE in the same cycle.
- Border rule: if row<2, row>HEIGHT-3, col<2 or col>WIDTH-3, the result equals the center pixel unchanged. This covers row wrap-around of taps and the zero padding at frame end.
- Interior arithmetic:
  - weights w=[1,4,6,4,1]; tap (dr,dc) weight = w[dr+2]*w[dc+2]; weights sum to 256;
  - 16-bit unsigned accumulator; max 255*256=65280;
  - result = (sum+128)>>8, clamped to 255 (clamp never triggers on legal input).
- Exactly WIDTH*HEIGHT pops and WIDTH*HEIGHT writes per frame, in raster order.
- Reset (any cycle, including mid-frame):
  - state goes to PROLOGUE; all counters, the shift register and the result register clear to 0;
  - in_rd_en=0, out_wr_en=0, out_din=0 while reset=1;
  - FIFO contents are not touched; the next popped pixel is treated as pixel (0,0).

## Timing
- in_rd_en, out_wr_en and out_din are combinational from registered state and the FIFO flags. No registered handshake delay.
- With in_empty=0 and out_full=0 continuously from cycle 0 after reset deassertion:
  - pops occur on cycles 0..2*WIDTH+2;
  - COMPUTE on cycle 2*WIDTH+3;
  - first out_wr_en on cycle 2*WIDTH+4.
- Steady-state throughput: 1 pixel per 3 cycles (ADVANCE, COMPUTE, WRITE).
- Stalls:
  - out_full=1 in WRITE holds state, result and all counters indefinitely;
  - in_empty=1 in PROLOGUE or ADVANCE (while input pixels remain) holds indefinitely;
  - neither stall drops nor duplicates data.
- Back-to-back frames: the cycle after the last write is PROLOGUE, and the first pop of the next frame may occur on that cycle.

## Test plan
- Uniform frame: WIDTH=HEIGHT=8, all pixels 100 -> 64 writes, every out_din=100 (interior (25600+128)>>8=100).
- Impulse: WIDTH=HEIGHT=9, pixel (4,4)=255, rest 0 -> expected outputs:
  - (4,4)=36, (3,4)=24, (4,3)=24, (3,3)=16, (2,4)=6, (2,2)=1;
  - all border pixels 0;
  - 81 writes total.
- Border pass-through: WIDTH=HEIGHT=8, pixel=r*8+c -> outputs at rows 0,1,6,7 and cols 0,1,6,7 equal the input exactly; interior pixels match the golden model.
- Backpressure: uniform-ramp frame, out_full held high 20 cycles while the 10th pixel is in WRITE -> out_wr_en=0 and in_rd_en=0 throughout; the output stream is identical to the unstalled run; exactly 64 writes.
- Starvation: in_empty randomly toggled (50%) over 3 back-to-back random frames -> in_rd_en never high with in_empty=1; outputs match the golden model per frame; 3*64 writes.
- Reset mid-frame: assert reset for 1 cycle after 30 writes, then feed a fresh uniform-50 frame -> outputs 0 during the reset cycle; next frame yields 64 writes of 50.

Source files
------------

// File: rtl/gaussian_blur.sv
`default_nettype none
// ============================================================================
// gaussian_blur : streaming 5x5 binomial smoothing stage, FIFO in / FIFO out
// Revision 1.0
// ============================================================================
module gaussian_blur #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64
) (
  input  logic       clock,
  input  logic       reset,
  output logic       in_rd_en,
  input  logic       in_empty,
  input  logic [7:0] in_dout,
  output logic       out_wr_en,
  input  logic       out_full,
  output logic [7:0] out_din
);

  localparam int L    = 4*WIDTH + 5;
  localparam int C    = 2*WIDTH + 2;
  localparam int NPIX = WIDTH*HEIGHT;
  localparam int CW   = $clog2(WIDTH);
  localparam int RW   = $clog2(HEIGHT);
  localparam int NW   = $clog2(NPIX + 1);
  localparam int PW   = $clog2(C + 2);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] COL_HI   = CW'(WIDTH - 3);
  localparam logic [CW-1:0] COL_LO   = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_HI   = RW'(HEIGHT - 3);
  localparam logic [RW-1:0] ROW_LO   = RW'(2);
  localparam logic [NW-1:0] NPIX_V   = NW'(NPIX);
  localparam logic [PW-1:0] PRO_LAST = PW'(C);

  typedef enum logic [1:0] {
    PROLOGUE = 2'd0,
    COMPUTE  = 2'd1,
    WRITE    = 2'd2,
    ADVANCE  = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    shreg [L];
  logic [NW-1:0] read_cnt;
  logic [PW-1:0] pro_cnt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [7:0]    result;

  logic          more;
  logic          shift_en;
  logic [7:0]    shift_val;
  logic          frame_done;
  logic [15:0]   sum;
  logic [16:0]   rounded;
  logic [7:0]    filtered;
  logic          border;
  logic [7:0]    pixel_out;

  function automatic logic [15:0] kw(input int i);
    case (i)
      0, 4:    kw = 16'd1;
      1, 3:    kw = 16'd4;
      default: kw = 16'd6;
    endcase
  endfunction

  assign more = (read_cnt < NPIX_V);

  always_comb begin
    in_rd_en = 1'b0;
    if (!reset && !in_empty) begin
      case (state)
        PROLOGUE: in_rd_en = 1'b1;
        ADVANCE:  in_rd_en = more;
        default:  in_rd_en = 1'b0;
      endcase
    end
  end

  assign out_wr_en  = !reset && (state == WRITE) && !out_full;
  assign out_din    = out_wr_en ? result : 8'h00;
  assign frame_done = out_wr_en && (row == ROW_LAST) && (col == COL_LAST);

  // Once the input is exhausted the window keeps sliding over zeros.
  assign shift_en  = ((state == PROLOGUE) && in_rd_en) ||
                     ((state == ADVANCE) && (in_rd_en || !more));
  assign shift_val = in_rd_en ? in_dout : 8'h00;

  always_comb begin
    sum = '0;
    for (int dr = 0; dr < 5; dr++) begin
      for (int dc = 0; dc < 5; dc++) begin
        sum = sum + kw(dr) * kw(dc) * {8'h00, shreg[C + (dr-2)*WIDTH + (dc-2)]};
      end
    end
  end

  assign rounded   = ({1'b0, sum} + 17'd128) >> 8;
  assign filtered  = (rounded > 17'd255) ? 8'hFF : rounded[7:0];
  assign border    = (row < ROW_LO) || (row > ROW_HI) || (col < COL_LO) || (col > COL_HI);
  assign pixel_out = border ? shreg[C] : filtered;

  always_ff @(posedge clock) begin
    if (reset || frame_done) begin
      for (int i = 0; i < L; i++) shreg[i] <= 8'h00;
    end else if (shift_en) begin
      for (int i = 0; i < L-1; i++) shreg[i] <= shreg[i+1];
      shreg[L-1] <= shift_val;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= PROLOGUE;
      read_cnt <= '0;
      pro_cnt  <= '0;
      row      <= '0;
      col      <= '0;
      result   <= 8'h00;
    end else begin
      case (state)
        PROLOGUE: begin
          if (in_rd_en) begin
            read_cnt <= read_cnt + NW'(1);
            pro_cnt  <= pro_cnt + PW'(1);
            if (pro_cnt == PRO_LAST) state <= COMPUTE;
          end
        end
        COMPUTE: begin
          result <= pixel_out;
          state  <= WRITE;
        end
        WRITE: begin
          if (out_wr_en) begin
            if (frame_done) begin
              row      <= '0;
              col      <= '0;
              read_cnt <= '0;
              pro_cnt  <= '0;
              state    <= PROLOGUE;
            end else begin
              if (col == COL_LAST) begin
                col <= '0;
                row <= row + RW'(1);
              end else begin
                col <= col + CW'(1);
              end
              state <= ADVANCE;
            end
          end
        end
        default: begin
          if (!more) begin
            state <= COMPUTE;
          end else if (in_rd_en) begin
            read_cnt <= read_cnt + NW'(1);
            state    <= COMPUTE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
